// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM responder.
// Size codes, default depths and the response entry layout.
package data_sram_responder_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int OUTSTANDING_DEF = 2;
  localparam int RESP_DELAY_DEF  = 0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] data;
  } resp_ent_t;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order response entry store: head/tail/count plus a
// late data write port for SRAM read data arriving a cycle later.
module data_sram_responder_resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEF,
  parameter int IW    = idx_w(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  resp_ent_t     push_ent,
  input  logic          pop,
  input  logic          cap_en,
  input  logic [IW-1:0] cap_idx,
  input  logic [31:0]   cap_data,
  output resp_ent_t     head_ent,
  output logic [IW-1:0] head_idx,
  output logic [IW-1:0] tail_idx,
  output logic [CW-1:0] count
);

  localparam int NS = 1 << IW;

  resp_ent_t     slot [NS];
  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [CW-1:0] cnt;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    if (DEPTH == 1) return '0;
    return p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < NS; i++) slot[i] <= '0;
    end else begin
      if (cap_en) slot[cap_idx].data <= cap_data;
      // a freshly accepted entry always wins its slot
      if (push) begin
        slot[tail] <= push_ent;
        tail       <= nxt(tail);
      end
      if (pop) head <= nxt(head);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_ent = slot[head];
  assign head_idx = head;
  assign tail_idx = tail;
  assign count    = cnt;

endmodule

// File: rtl/data_sram_responder.sv
// SRAM-like data interface responder with in-order data_ok.
// req/addr in, addr_ok/data_ok/rdata out, ram_* to a 1-cycle SRAM.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int OUTSTANDING = OUTSTANDING_DEF,
  parameter int RESP_DELAY  = RESP_DELAY_DEF,
  parameter int RAM_AW      = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int IW = idx_w(OUTSTANDING);
  localparam int CW = $clog2(OUTSTANDING + 1);

  logic [CW-1:0] count;
  logic [IW-1:0] head_idx;
  logic [IW-1:0] tail_idx;
  logic [IW-1:0] pend_idx;
  logic          pending;
  logic          armed;
  logic [3:0]    dly;
  logic [3:0]    dly_eff;
  logic          accept;
  logic          pop;
  logic          busy;
  logic          bypass;
  resp_ent_t     head_ent;
  resp_ent_t     push_ent;
  logic          unused_bits;

  assign accept = req && resetn && (count < CW'(OUTSTANDING));
  assign busy   = (count != '0);

  // a head that was not armed yet sees a freshly loaded counter
  assign dly_eff = armed ? dly : 4'(RESP_DELAY);
  assign pop     = resetn && busy && (dly_eff == 4'd0);

  assign addr_ok   = accept;
  assign data_ok   = pop;
  assign ram_en    = accept;
  assign ram_wen   = (accept && wr) ? wstrb : 4'b0;
  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_wdata = wdata;

  assign push_ent = '{wr: wr, size: size, data: 32'd0};

  // read data still on the SRAM bus when its entry pops
  assign bypass = pop && pending && (pend_idx == head_idx);
  assign rdata  = bypass ? ram_rdata : head_ent.data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending  <= 1'b0;
      pend_idx <= '0;
      armed    <= 1'b0;
      dly      <= 4'd0;
    end else begin
      pending <= accept && !wr;
      if (accept && !wr) pend_idx <= tail_idx;
      if (pop) begin
        armed <= 1'b0;
      end else if (busy) begin
        armed <= 1'b1;
        dly   <= dly_eff - 4'd1;
      end
    end
  end

  data_sram_responder_resp_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_ent (push_ent),
    .pop      (pop),
    .cap_en   (pending),
    .cap_idx  (pend_idx),
    .cap_data (ram_rdata),
    .head_ent (head_ent),
    .head_idx (head_idx),
    .tail_idx (tail_idx),
    .count    (count)
  );

  assign unused_bits = ^{head_ent.wr, head_ent.size,
                         addr[31:RAM_AW+2], addr[1:0]};

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: four configurations against a
// response-time model plus directed literal scenarios.
module tb_data_sram_responder;
  import data_sram_responder_pkg::*;

  localparam int N  = 4;
  localparam int AW = 10;

  function automatic int out_of(input int k);
    case (k)
      0: return 2;
      1: return 2;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int dly_of(input int k);
    case (k)
      0: return 0;
      1: return 3;
      2: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] preload(input int i);
    return 32'(i) * 32'h9E3779B9 ^ 32'hA5A50000;
  endfunction

  logic clk;
  logic resetn;
  logic [N-1:0]           req;
  logic [N-1:0]           wr;
  logic [N-1:0][1:0]      size;
  logic [N-1:0][3:0]      wstrb;
  logic [N-1:0][31:0]     addr;
  logic [N-1:0][31:0]     wdata;
  logic [N-1:0]           addr_ok;
  logic [N-1:0]           data_ok;
  logic [N-1:0][31:0]     rdata;
  logic [N-1:0]           ram_en;
  logic [N-1:0][3:0]      ram_wen;
  logic [N-1:0][AW-1:0]   ram_addr;
  logic [N-1:0][31:0]     ram_wdata;
  logic [N-1:0][31:0]     ram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_inst
    logic [31:0] mem [1<<AW];
    logic [31:0] rd_q;
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = preload(i);
    always @(posedge clk) begin
      if (ram_en[g]) begin
        rd_q <= mem[ram_addr[g]];
        for (int b = 0; b < 4; b++)
          if (ram_wen[g][b])
            mem[ram_addr[g]][8*b+:8] <= ram_wdata[g][8*b+:8];
      end
    end
    assign ram_rdata[g] = rd_q;

    data_sram_responder #(
      .OUTSTANDING (out_of(g)),
      .RESP_DELAY  (dly_of(g)),
      .RAM_AW      (AW)
    ) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req[g]),
      .wr        (wr[g]),
      .size      (size[g]),
      .wstrb     (wstrb[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .addr_ok   (addr_ok[g]),
      .data_ok   (data_ok[g]),
      .rdata     (rdata[g]),
      .ram_en    (ram_en[g]),
      .ram_wen   (ram_wen[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: responses are due at max(accept+1, prev+1)+delay,
  // read data is the memory word at accept time.
  logic [31:0] ref_mem [N][1<<AW];
  int          qt [N][8];
  logic [31:0] qd [N][8];
  int          qh [N];
  int          qn [N];
  int          last [N];
  int          cyc = 0;
  bit          inited = 0;

  always @(negedge clk) begin
    logic ea, ed;
    int idx, prev, t, tl;
    logic [31:0] d;
    if (!inited) begin
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[k][i] = preload(i);
        qh[k] = 0; qn[k] = 0; last[k] = -1000;
      end
      inited = 1;
    end
    for (int k = 0; k < N; k++) begin
      if (!resetn) begin
        chk($sformatf("k%0d rst aok", k), 32'(addr_ok[k]), 0);
        chk($sformatf("k%0d rst dok", k), 32'(data_ok[k]), 0);
        chk($sformatf("k%0d rst en", k), 32'(ram_en[k]), 0);
        chk($sformatf("k%0d rst wen", k), 32'(ram_wen[k]), 0);
        chk($sformatf("k%0d rst rdata", k), rdata[k], 0);
        qh[k] = 0; qn[k] = 0; last[k] = -1000;
      end else begin
        ea = req[k] && (qn[k] < out_of(k));
        ed = (qn[k] > 0) && (qt[k][qh[k]] == cyc);
        chk($sformatf("k%0d c%0d aok", k, cyc), 32'(addr_ok[k]), 32'(ea));
        chk($sformatf("k%0d c%0d dok", k, cyc), 32'(data_ok[k]), 32'(ed));
        chk($sformatf("k%0d c%0d en", k, cyc), 32'(ram_en[k]), 32'(ea));
        chk($sformatf("k%0d c%0d wen", k, cyc), 32'(ram_wen[k]),
            (ea && wr[k]) ? 32'(wstrb[k]) : 0);
        if (ea) begin
          chk($sformatf("k%0d c%0d raddr", k, cyc), 32'(ram_addr[k]),
              32'(addr[k][AW+1:2]));
          chk($sformatf("k%0d c%0d wdat", k, cyc), ram_wdata[k], wdata[k]);
        end
        if (ed) begin
          chk($sformatf("k%0d c%0d rdata", k, cyc), rdata[k], qd[k][qh[k]]);
          qh[k] = (qh[k] + 1) % 8;
          qn[k]--;
          last[k] = cyc;
        end
        if (ea) begin
          idx = int'(addr[k][AW+1:2]);
          d = wr[k] ? 32'd0 : ref_mem[k][idx];
          if (wr[k])
            for (int b = 0; b < 4; b++)
              if (wstrb[k][b]) ref_mem[k][idx][8*b+:8] = wdata[k][8*b+:8];
          prev = (qn[k] > 0) ? qt[k][(qh[k] + qn[k] - 1) % 8] : last[k];
          t = ((cyc + 1 > prev + 1) ? cyc + 1 : prev + 1) + dly_of(k);
          tl = (qh[k] + qn[k]) % 8;
          qt[k][tl] = t;
          qd[k][tl] = d;
          qn[k]++;
        end
      end
    end
    cyc++;
  end

  task automatic drive(input int k, input logic r, input logic w,
                       input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d);
    req[k] = r; wr[k] = w; wstrb[k] = s;
    addr[k] = a; wdata[k] = d; size[k] = SIZE_W;
  endtask

  task automatic idle_all();
    for (int k = 0; k < N; k++) drive(k, 0, 0, 4'h0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int k, input logic r, input logic w,
                      input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, input logic e_aok,
                      input logic e_dok, input logic [31:0] e_rd,
                      input string nm);
    tick();
    idle_all();
    drive(k, r, w, s, a, d);
    @(negedge clk);
    chk({nm, " aok"}, 32'(addr_ok[k]), 32'(e_aok));
    chk({nm, " dok"}, 32'(data_ok[k]), 32'(e_dok));
    if (e_dok) chk({nm, " rdata"}, rdata[k], e_rd);
  endtask

  initial begin
    int acc, rsp;
    logic [31:0] a;
    resetn = 1'b0;
    for (int k = 0; k < N; k++) drive(k, 1, k[0], 4'hF, 32'h40, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle_all();

    step(0, 1, 1, 4'hF, 32'h100, 32'hDEADBEEF, 1, 0, 0, "wr1");
    step(0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h0, "wr1 rsp");
    step(0, 1, 0, 4'h0, 32'h100, 0, 1, 0, 0, "rd1");
    step(0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hDEADBEEF, "rd1 rsp");
    step(0, 1, 1, 4'hF, 32'h100, 32'h11223344, 1, 0, 0, "wfull");
    step(0, 1, 1, 4'h8, 32'h103, 32'h5A5A5A5A, 1, 1, 0, "sb");
    step(0, 1, 1, 4'h0, 32'h100, 32'hFFFFFFFF, 1, 1, 0, "nopwr");
    step(0, 1, 0, 4'h0, 32'h100, 0, 1, 1, 0, "rd2");
    step(0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h5A223344, "rd2 rsp");

    for (int c = 0; c <= 8; c++)
      step(0, c < 8, 0, 4'h0, 32'h80 + 32'(4 * c), 0, c < 8, c > 0,
           preload(32 + c - 1), $sformatf("b2b%0d", c));

    acc = 0;
    rsp = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      idle_all();
      if (acc < 3) drive(1, 1, 0, 4'h0, 32'(4 * acc), 0);
      @(negedge clk);
      chk($sformatf("full c%0d aok", c), 32'(addr_ok[1]),
          32'(c == 0 || c == 1 || c == 5));
      chk($sformatf("full c%0d dok", c), 32'(data_ok[1]),
          32'(c == 4 || c == 8 || c == 12));
      if (data_ok[1]) begin
        chk($sformatf("full r%0d", rsp), rdata[1], preload(rsp));
        rsp++;
      end
      if (addr_ok[1]) acc++;
    end

    step(1, 1, 0, 4'h0, 32'h10, 0, 1, 0, 0, "mid rd0");
    step(1, 1, 0, 4'h0, 32'h14, 0, 1, 0, 0, "mid rd1");
    step(1, 0, 0, 4'h0, 0, 0, 0, 0, 0, "mid w2");
    step(1, 0, 0, 4'h0, 0, 0, 0, 0, 0, "mid w3");
    tick();
    drive(1, 1, 0, 4'h0, 32'h18, 0);
    #1;
    chk("mid pre dok", 32'(data_ok[1]), 1);
    chk("mid pre aok", 32'(addr_ok[1]), 0);
    #1;
    resetn = 1'b0;
    #1;
    chk("mid rst dok", 32'(data_ok[1]), 0);
    chk("mid rst aok", 32'(addr_ok[1]), 0);
    chk("mid rst rdata", rdata[1], 0);
    tick();
    tick();
    resetn = 1'b1;
    idle_all();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("stale c%0d", c), 32'(data_ok[1]), 0);
      tick();
    end
    step(0, 1, 0, 4'h0, 32'h100, 0, 1, 0, 0, "post rd");
    step(0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h5A223344, "post rsp");

    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!resetn) resetn = 1'b1;
      for (int k = 0; k < N; k++) begin
        a = $urandom();
        a[AW+1:2] = AW'($urandom_range(0, 15));
        drive(k, $urandom_range(0, 99) < 65, 1'($urandom_range(0, 1)),
              4'($urandom()), a, $urandom());
        size[k] = 2'($urandom_range(0, 2));
      end
      if (i % 700 == 350) begin
        #2;
        resetn = 1'b0;
      end
    end
    tick();
    resetn = 1'b1;
    idle_all();
    repeat (20) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
